// File: rtl/mux4_rr_arbiter_if.sv
// Handshake and select bundle shared by four requesters, the arbiter and the single output.
// The slave side is the arbiter; the master side is the surrounding router logic.
interface mux4_rr_arbiter_if;
  logic [3:0] in_valid;
  logic [3:0] in_last;
  logic [3:0] in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [1:0] mux_sel;
  logic [3:0] grant;
  logic       busy;

  modport master (
    output in_valid, in_last, out_ready,
    input  in_ready, out_valid, out_last, mux_sel, grant, busy
  );

  modport slave (
    input  in_valid, in_last, out_ready,
    output in_ready, out_valid, out_last, mux_sel, grant, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin packet arbiter steering a shared 4:1 mux; a grant is held for one packet
// (BURST_LEN beats or the last flag), followed by a single-cycle arbitration bubble.
module mux4_rr_arbiter #(
  parameter int BURST_LEN = 4,
  parameter bit USE_LAST  = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  mux4_rr_arbiter_if.slave bus
);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [1:0]       rr_ptr_reg, rr_ptr_next;
  logic [1:0]       sel_reg, sel_next;
  logic [3:0]       grant_reg, grant_next;
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

  logic [1:0] cand_idx [4];
  logic [3:0] rot_valid;
  logic [1:0] win_off;
  logic [1:0] winner;
  logic       locked;
  logic       out_valid_w;
  logic       accept;
  logic       pkt_end;

  // rot_valid[0] is the requester at rr_ptr, so the lowest set bit is the fair winner.
  for (genvar gi = 0; gi < 4; gi++) begin : g_scan
    assign cand_idx[gi]    = rr_ptr_reg + 2'(gi);
    assign rot_valid[gi]   = bus.in_valid[cand_idx[gi]];
    assign bus.in_ready[gi] = grant_reg[gi] & bus.out_ready;
  end

  always_comb begin
    win_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_valid[k]) win_off = 2'(k);
    end
  end

  assign winner      = rr_ptr_reg + win_off;
  assign locked      = (state_reg == LOCKED);
  assign out_valid_w = locked & bus.in_valid[sel_reg];
  assign accept      = out_valid_w & bus.out_ready;
  assign pkt_end     = (USE_LAST & bus.in_last[sel_reg]) | (beat_cnt_reg == CNT_MAX);

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    sel_next      = sel_reg;
    grant_next    = grant_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|bus.in_valid) begin
          state_next    = LOCKED;
          sel_next      = winner;
          grant_next    = 4'b0001 << winner;
          beat_cnt_next = '0;
        end
      end
      default: begin
        if (accept) begin
          if (pkt_end) begin
            state_next    = IDLE;
            grant_next    = 4'b0000;
            rr_ptr_next   = sel_reg + 2'd1;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // mux_sel is not cleared on release so the datapath select stays quiet while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= 2'd0;
      sel_reg      <= 2'd0;
      grant_reg    <= 4'b0000;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      sel_reg      <= sel_next;
      grant_reg    <= grant_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  assign bus.out_valid = out_valid_w;
  assign bus.out_last  = out_valid_w & bus.in_last[sel_reg];
  assign bus.mux_sel   = sel_reg;
  assign bus.grant     = grant_reg;
  assign bus.busy      = locked;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed scenarios followed by a randomized run, every cycle compared against a
// packet-level reference model of the arbiter.
module tb_mux4_rr_arbiter;
  localparam int BURST_LEN = 4;
  localparam bit USE_LAST  = 1'b1;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] iv;
  logic [3:0] il;
  logic       ordy;

  mux4_rr_arbiter_if bus ();

  assign bus.in_valid  = iv;
  assign bus.in_last   = il;
  assign bus.out_ready = ordy;

  mux4_rr_arbiter #(
    .BURST_LEN (BURST_LEN),
    .USE_LAST  (USE_LAST)
  ) dut (
    .clk   (clk),
    .rst_n (rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: who owns the output (-1 = nobody), where the next search starts,
  // how many beats the current packet has delivered, and the last select value.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_sel   = 0;

  int         grant_log[$];
  int         obs_beats = 0;
  logic [3:0] prev_grant = 4'b0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle();
    logic [3:0] eg;
    logic [3:0] er;
    logic       ev;
    logic       el;
    logic       eb;
    #2;
    eg = 4'b0000;
    ev = 1'b0;
    el = 1'b0;
    eb = 1'b0;
    if (m_owner >= 0) begin
      eg = 4'(1 << m_owner);
      ev = iv[m_owner];
      el = ev & il[m_owner];
      eb = 1'b1;
    end
    er = ordy ? eg : 4'b0000;
    chk("grant",     32'(bus.grant),     32'(eg));
    chk("mux_sel",   32'(bus.mux_sel),   32'(m_sel));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("out_last",  32'(bus.out_last),  32'(el));
    chk("in_ready",  32'(bus.in_ready),  32'(er));
    chk("busy",      32'(bus.busy),      32'(eb));

    if (bus.grant != 4'b0000 && prev_grant == 4'b0000) begin
      for (int k = 0; k < 4; k++) if (bus.grant[k]) grant_log.push_back(k);
    end
    prev_grant = bus.grant;
    if (bus.out_valid && ordy) begin
      obs_beats++;
      $display("beat t=%0t sel=%0d last=%0b", $time, bus.mux_sel, bus.out_last);
    end

    @(posedge clk);
    if (!rstn) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && iv[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_sel   = m_owner;
          m_beats = 0;
        end
      end
    end else if (ev && ordy) begin
      m_beats++;
      if ((USE_LAST && il[m_owner]) || m_beats == BURST_LEN) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_beats = 0;
      end
    end
    #1;
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};
  logic bp_seq[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    // 1: reset with all requesters valid
    rstn = 1'b0;
    iv   = 4'hF;
    il   = 4'h0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    chk("t1_grant", 32'(bus.grant), 32'h0);
    chk("t1_out_valid", 32'(bus.out_valid), 32'h0);
    chk("t1_in_ready", 32'(bus.in_ready), 32'h0);
    chk("t1_mux_sel", 32'(bus.mux_sel), 32'h0);
    rstn = 1'b1;

    // 2: single requester, full-length packet, then pointer moves past it
    iv = 4'b0100;
    cycle();
    chk("t2_grant", 32'(bus.grant), 32'h4);
    chk("t2_mux_sel", 32'(bus.mux_sel), 32'h2);
    obs_beats = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t2_beats", 32'(obs_beats), 32'd4);
    chk("t2_released", 32'(bus.grant), 32'h0);
    iv = 4'b1101;
    cycle();
    chk("t2_next_from_ptr3", 32'(bus.grant), 32'h8);
    il = 4'hF;
    cycle();
    il = 4'h0;
    iv = 4'h0;
    cycle();

    // 3: all requesters busy, two-beat packets
    grant_log.delete();
    obs_beats = 0;
    iv = 4'hF;
    for (int p = 0; p < 5; p++) begin
      il = 4'h0;
      cycle();
      cycle();
      il = 4'hF;
      cycle();
    end
    il = 4'h0;
    iv = 4'h0;
    chk("t3_packets", 32'(grant_log.size()), 32'd5);
    for (int p = 0; p < 5 && p < grant_log.size(); p++)
      chk("t3_order", 32'(grant_log[p]), 32'(exp_rr[p]));
    chk("t3_beats", 32'(obs_beats), 32'd10);

    // 4: backpressure on requester 1
    iv = 4'b0010;
    cycle();
    chk("t4_grant", 32'(bus.grant), 32'h2);
    obs_beats = 0;
    for (int i = 0; i < 6; i++) begin
      ordy = bp_seq[i];
      #1;
      chk("t4_in_ready1", 32'(bus.in_ready[1]), 32'(bp_seq[i]));
      cycle();
    end
    chk("t4_beats", 32'(obs_beats), 32'd4);
    chk("t4_released", 32'(bus.grant), 32'h0);
    ordy = 1'b1;

    // 5: granted requester 3 drops valid mid-packet
    iv = 4'b1000;
    cycle();
    chk("t5_grant", 32'(bus.grant), 32'h8);
    cycle();
    iv = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t5_hold", 32'(bus.grant), 32'h8);
      chk("t5_no_valid", 32'(bus.out_valid), 32'h0);
    end
    iv = 4'hF;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_released", 32'(bus.grant), 32'h0);
    cycle();
    chk("t5_wrap_to_0", 32'(bus.grant), 32'h1);
    il = 4'hF;
    cycle();
    il = 4'h0;

    // 6: reset in the middle of a packet from requester 1
    cycle();
    chk("t6_grant", 32'(bus.grant), 32'h2);
    cycle();
    cycle();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    chk("t6_reset_grant", 32'(bus.grant), 32'h0);
    cycle();
    chk("t6_ptr_zero", 32'(bus.grant), 32'h1);
    for (int i = 0; i < 3; i++) cycle();
    chk("t6_still_locked", 32'(bus.grant), 32'h1);
    cycle();
    chk("t6_full_burst", 32'(bus.grant), 32'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      iv   = 4'($urandom);
      il   = 4'($urandom) & 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      rstn = ($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
